// File: rtl/cpu_pkg.sv
// Shared opcodes, ALU select codes, FSM states and instruction layout for the
// simple processor controller.
package cpu_pkg;

  localparam logic [2:0] OP_MOV  = 3'b000;
  localparam logic [2:0] OP_TSTZ = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_LDI  = 3'b101;
  localparam logic [2:0] OP_JZ   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  // ALU select codes are the opcodes themselves for the ALU-class ops
  localparam logic [2:0] ALU_MOV  = OP_MOV;
  localparam logic [2:0] ALU_TSTZ = OP_TSTZ;
  localparam logic [2:0] ALU_ADD  = OP_ADD;
  localparam logic [2:0] ALU_SUB  = OP_SUB;
  localparam logic [2:0] ALU_SHL  = OP_SHL;

  localparam int IR_OP_MSB  = 15;
  localparam int IR_OP_LSB  = 13;
  localparam int IR_RD_MSB  = 12;
  localparam int IR_RD_LSB  = 11;
  localparam int IR_RS_MSB  = 10;
  localparam int IR_RS_LSB  = 9;
  localparam int IR_RSVD    = 8;
  localparam int IR_IMM_MSB = 7;
  localparam int IR_IMM_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic       rsvd;
    logic [7:0] imm;
  } instr_t;

  function automatic instr_t decode(input logic [15:0] w);
    instr_t i;
    i.op   = w[IR_OP_MSB:IR_OP_LSB];
    i.rd   = w[IR_RD_MSB:IR_RD_LSB];
    i.rs   = w[IR_RS_MSB:IR_RS_LSB];
    i.rsvd = w[IR_RSVD];
    i.imm  = w[IR_IMM_MSB:IR_IMM_LSB];
    return i;
  endfunction

endpackage

// File: rtl/cpu_ctrl_regfile4.sv
// 4-entry register file: two combinational read ports, one synchronous write
// port, async clear; R0 is exported for debug.
module regfile4 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [1:0]    rb_addr,
  output logic [DW-1:0] rb_data,
  input  logic          we,
  input  logic [1:0]    wa,
  input  logic [DW-1:0] wd,
  output logic [DW-1:0] r0
);

  logic [3:0][DW-1:0] regs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     regs <= '0;
    else if (we) regs[wa] <= wd;
  end

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];
  assign r0      = regs[0];

endmodule

// File: rtl/cpu_ctrl.sv
// Fetch/decode/execute sequencer: drives a 1-cycle-latency ALU, writes results
// back, and handles the zero-flag branch and HALT.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int DW       = 8,
  parameter int AW       = 8,
  parameter int START_PC = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] imem_addr,
  input  logic [15:0]   imem_data,
  output logic          alu_en,
  output logic [2:0]    alu_sel,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_zero,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic [DW-1:0] dbg_r0
);

  state_t        state;
  instr_t        ir;
  logic          zflag;
  logic [DW-1:0] rd_data, rs_data, rf_wd;
  logic          rf_we;
  logic          unused_rsvd;

  assign imem_addr   = pc;
  assign unused_rsvd = ir.rsvd;

  regfile4 #(.DW(DW)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (ir.rd),
    .ra_data (rd_data),
    .rb_addr (ir.rs),
    .rb_data (rs_data),
    .we      (rf_we),
    .wa      (ir.rd),
    .wd      (rf_wd),
    .r0      (dbg_r0)
  );

  // ALU request is decoded from state so a reset kills it in the same cycle
  always_comb begin
    alu_en  = 1'b0;
    alu_sel = '0;
    alu_in1 = '0;
    alu_in2 = '0;
    if (state == S_EXEC) begin
      case (ir.op)
        ALU_MOV, ALU_TSTZ: begin
          alu_en  = 1'b1;
          alu_sel = ir.op;
          alu_in1 = rs_data;
        end
        ALU_ADD, ALU_SUB, ALU_SHL: begin
          alu_en  = 1'b1;
          alu_sel = ir.op;
          alu_in1 = rd_data;
          alu_in2 = rs_data;
        end
        default: ;
      endcase
    end
  end

  // LDI writes at the end of EXEC; ALU results land at the end of WB
  always_comb begin
    rf_we = 1'b0;
    rf_wd = alu_out;
    if (state == S_EXEC && ir.op == OP_LDI) begin
      rf_we = 1'b1;
      rf_wd = DW'(ir.imm);
    end else if (state == S_WB && ir.op != OP_TSTZ) begin
      rf_we = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= AW'(START_PC);
      ir     <= '0;
      zflag  <= 1'b0;
      halted <= 1'b0;
    end else begin
      case (state)
        S_IDLE:   if (start) state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          ir    <= decode(imem_data);
          pc    <= pc + AW'(1);
          state <= S_EXEC;
        end
        S_EXEC: begin
          case (ir.op)
            OP_MOV, OP_TSTZ, OP_ADD, OP_SUB, OP_SHL: state <= S_WB;
            OP_LDI: state <= S_FETCH;
            OP_JZ: begin
              if (zflag) pc <= AW'(ir.imm);
              state <= S_FETCH;
            end
            default: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
          endcase
        end
        // alu_zero is stale outside a TSTZ writeback, so sample it only here
        S_WB: begin
          if (ir.op == OP_TSTZ) zflag <= alu_zero;
          state <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed + random programs run on cpu_ctrl, checked against an ISA-level
// interpreter (register results, final pc, cycle count, ALU requests).
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic [15:0] rom [256];
  logic [15:0] imem_data, w_data;
  logic [7:0]  imem_addr, pc, dbg_r0, alu_in1, alu_in2, alu_out;
  logic [2:0]  alu_sel, w_sel;
  logic        alu_en, alu_zero, halted;
  logic [7:0]  w_addr, w_pc, w_r0, w_in1, w_in2;
  logic        w_en, w_halted;

  int n_cmp = 0;
  int n_err = 0;

  logic [18:0] obs [4096];
  int          obs_n = 0;
  int          b2b = 0;
  logic        prev_en = 1'b0;

  logic [18:0] exp_alu [$];
  logic [7:0]  m_r0, m_pc;
  int          m_cyc;
  int          last_cyc, last_base;

  always #5 clk = ~clk;

  cpu_ctrl #(.DW(8), .AW(8), .START_PC(0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .alu_en(alu_en), .alu_sel(alu_sel), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .pc(pc), .halted(halted), .dbg_r0(dbg_r0)
  );

  cpu_ctrl #(.DW(8), .AW(8), .START_PC(255)) u_wrap (
    .clk(clk), .rst(rst), .start(start2),
    .imem_addr(w_addr), .imem_data(w_data),
    .alu_en(w_en), .alu_sel(w_sel), .alu_in1(w_in1), .alu_in2(w_in2),
    .alu_out(8'h00), .alu_zero(1'b0),
    .pc(w_pc), .halted(w_halted), .dbg_r0(w_r0)
  );

  // synchronous ROMs
  always @(posedge clk) begin
    imem_data <= rom[imem_addr];
    w_data    <= rom[w_addr];
  end

  // ALU stub: registered result, unreset, holds out on TSTZ
  always @(posedge clk) begin : alu_stub
    logic [7:0] res;
    if (alu_en) begin
      case (alu_sel)
        3'd0:    res = alu_in1;
        3'd2:    res = alu_in1 + alu_in2;
        3'd3:    res = alu_in1 - alu_in2;
        3'd4:    res = (alu_in2 >= 8'd8) ? 8'd0 : 8'(alu_in1 << alu_in2);
        default: res = alu_out;
      endcase
      alu_out  <= res;
      alu_zero <= (alu_sel == 3'd1) ? (alu_in1 == 8'd0) : (res == 8'd0);
    end
  end

  // record every ALU request
  always @(negedge clk) begin
    if (alu_en && obs_n < 4096) begin
      obs[obs_n] = {alu_sel, alu_in1, alu_in2};
      obs_n++;
    end
    if (alu_en && prev_en) b2b++;
    prev_en = alu_en;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, 1'b0, imm};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = enc(3'd7, 2'd0, 2'd0, 8'd0);
  endtask

  // ISA interpreter: one instruction per iteration, CPI per opcode class
  task automatic model_run(input logic [7:0] spc);
    logic [7:0]  r [4];
    logic [7:0]  mpc, imm;
    logic [15:0] w;
    logic [2:0]  op;
    logic [1:0]  rd, rs;
    logic        z;
    for (int k = 0; k < 4; k++) r[k] = 8'd0;
    z = 1'b0; mpc = spc; m_cyc = 0;
    exp_alu.delete();
    for (int s = 0; s < 1000; s++) begin
      w = rom[mpc]; op = w[15:13]; rd = w[12:11]; rs = w[10:9]; imm = w[7:0];
      mpc = mpc + 8'd1;
      if (op == 3'd7) begin m_cyc += 3; break; end
      case (op)
        3'd0: begin exp_alu.push_back({op, r[rs], 8'd0}); r[rd] = r[rs]; end
        3'd1: begin exp_alu.push_back({op, r[rs], 8'd0}); z = (r[rs] == 8'd0); end
        3'd2: begin exp_alu.push_back({op, r[rd], r[rs]}); r[rd] = r[rd] + r[rs]; end
        3'd3: begin exp_alu.push_back({op, r[rd], r[rs]}); r[rd] = r[rd] - r[rs]; end
        3'd4: begin
          exp_alu.push_back({op, r[rd], r[rs]});
          r[rd] = (r[rs] > 8'd7) ? 8'd0 : 8'(r[rd] << r[rs]);
        end
        3'd5: r[rd] = imm;
        default: if (z) mpc = imm;
      endcase
      m_cyc += (op <= 3'd4) ? 4 : 3;
    end
    m_r0 = r[0];
    m_pc = mpc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_prog(input string tag);
    int cyc;
    model_run(8'd0);
    do_reset();
    last_base = obs_n;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (halted) break;
    end
    last_cyc = cyc;
    chk({tag, "_halt"}, 32'(halted), 32'd1);
    chk({tag, "_r0"},   32'(dbg_r0), 32'(m_r0));
    chk({tag, "_pc"},   32'(pc),     32'(m_pc));
    chk({tag, "_cyc"},  32'(cyc),    32'(m_cyc));
    chk({tag, "_nalu"}, 32'(obs_n - last_base), 32'(exp_alu.size()));
    for (int i = 0; i < exp_alu.size() && i < obs_n - last_base; i++)
      chk({tag, "_alu"}, 32'(obs[last_base + i]), 32'(exp_alu[i]));
  endtask

  initial begin
    logic [7:0] hold_pc, hold_r0;
    int         waited;

    clear_rom();
    do_reset();
    chk("rst_pc",     32'(pc),        32'd0);
    chk("rst_addr",   32'(imem_addr), 32'd0);
    chk("rst_halted", 32'(halted),    32'd0);
    chk("rst_r0",     32'(dbg_r0),    32'd0);
    chk("rst_alu_en", 32'(alu_en),    32'd0);
    chk("rst_w_addr", 32'(w_addr),    32'hFF);

    // LDI R0,5; LDI R1,3; ADD R0,R1; HALT
    clear_rom();
    rom[0] = enc(3'd5, 2'd0, 2'd0, 8'd5);
    rom[1] = enc(3'd5, 2'd1, 2'd0, 8'd3);
    rom[2] = enc(3'd2, 2'd0, 2'd1, 8'd0);
    run_prog("add");
    chk("add_r0_const", 32'(dbg_r0), 32'd8);
    chk("add_cyc_const", 32'(last_cyc), 32'd13);
    chk("add_npulse", 32'(obs_n - last_base), 32'd1);
    chk("add_req", 32'(obs[last_base]), 32'({3'b010, 8'd5, 8'd3}));

    // HALT ignores start
    hold_pc = pc; hold_r0 = dbg_r0;
    @(negedge clk) start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("halt_pc", 32'(pc), 32'(hold_pc));
      chk("halt_r0", 32'(dbg_r0), 32'(hold_r0));
      chk("halt_alu_en", 32'(alu_en), 32'd0);
      chk("halt_flag", 32'(halted), 32'd1);
    end
    start = 1'b0;

    // SUB wrap, SHL by >= 8
    clear_rom();
    rom[0] = enc(3'd5, 2'd0, 2'd0, 8'd2);
    rom[1] = enc(3'd5, 2'd1, 2'd0, 8'd7);
    rom[2] = enc(3'd3, 2'd0, 2'd1, 8'd0);
    run_prog("sub");
    chk("sub_r0_const", 32'(dbg_r0), 32'hFB);
    clear_rom();
    rom[0] = enc(3'd5, 2'd0, 2'd0, 8'd1);
    rom[1] = enc(3'd5, 2'd1, 2'd0, 8'd9);
    rom[2] = enc(3'd4, 2'd0, 2'd1, 8'd0);
    run_prog("shl");
    chk("shl_r0_const", 32'(dbg_r0), 32'd0);

    // TSTZ / JZ taken and not taken
    for (int v = 0; v < 2; v++) begin
      clear_rom();
      rom[0]     = enc(3'd5, 2'd2, 2'd0, 8'(v));
      rom[1]     = enc(3'd1, 2'd0, 2'd2, 8'd0);
      rom[2]     = enc(3'd6, 2'd0, 2'd0, 8'h10);
      rom[3]     = enc(3'd5, 2'd0, 2'd0, 8'h55);
      rom[8'h10] = enc(3'd5, 2'd0, 2'd0, 8'hAA);
      run_prog("jz");
      chk("jz_r0_const", 32'(dbg_r0), (v == 0) ? 32'hAA : 32'h55);
      chk("jz_pc_const", 32'(pc),     (v == 0) ? 32'h12 : 32'h05);
    end

    // JZ to the next pc is a no-op
    clear_rom();
    rom[0] = enc(3'd5, 2'd3, 2'd0, 8'd0);
    rom[1] = enc(3'd1, 2'd0, 2'd3, 8'd0);
    rom[2] = enc(3'd6, 2'd0, 2'd0, 8'd3);
    rom[3] = enc(3'd5, 2'd0, 2'd0, 8'h77);
    run_prog("jznext");
    chk("jznext_r0_const", 32'(dbg_r0), 32'h77);

    // pc wrap from 255
    clear_rom();
    rom[255] = enc(3'd5, 2'd0, 2'd0, 8'h3C);
    do_reset();
    chk("wrap_rst_addr", 32'(w_addr), 32'hFF);
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("wrap_next_addr", 32'(w_addr), 32'd0);
    waited = 0;
    while (!w_halted && waited < 20) begin @(negedge clk); waited++; end
    chk("wrap_halt", 32'(w_halted), 32'd1);
    chk("wrap_r0", 32'(w_r0), 32'h3C);
    chk("wrap_pc", 32'(w_pc), 32'd1);
    chk("wrap_alu_idle", 32'({w_en, w_sel, w_in1, w_in2}), 32'd0);

    // reset in EXEC of ADD
    clear_rom();
    rom[0] = enc(3'd5, 2'd0, 2'd0, 8'd5);
    rom[1] = enc(3'd5, 2'd1, 2'd0, 8'd3);
    rom[2] = enc(3'd2, 2'd0, 2'd1, 8'd0);
    do_reset();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    waited = 0;
    while (!alu_en && waited < 50) begin @(negedge clk); waited++; end
    chk("mid_saw_add", 32'({alu_en, alu_sel}), 32'({1'b1, 3'b010}));
    rst = 1'b1;
    #1;
    chk("mid_alu_en", 32'(alu_en), 32'd0);
    chk("mid_pc", 32'(pc), 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_r0", 32'(dbg_r0), 32'd0);
    chk("mid_idle_pc", 32'(pc), 32'd0);
    chk("mid_idle_alu", 32'(alu_en), 32'd0);

    // random forward-branching programs
    for (int t = 0; t < 10; t++) begin
      int         n;
      logic [2:0] op;
      logic [7:0] imm;
      clear_rom();
      n = int'($urandom_range(4, 12));
      for (int i = 0; i < n; i++) begin
        op  = 3'($urandom_range(0, 6));
        imm = 8'($urandom);
        if (op == 3'd6) imm = 8'($urandom_range(i + 1, n + 1));
        rom[i] = enc(op, 2'($urandom), 2'($urandom), imm) | ($urandom_range(0, 1) == 1 ? 16'h0100 : 16'h0000);
      end
      rom[n] = enc(3'd0, 2'd0, 2'($urandom), 8'd0);
      run_prog("rnd");
    end

    chk("alu_b2b", 32'(b2b), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
